// File: rtl/rr_arb_mux.sv
// rr_arb_mux: NUM_CH-channel valid/ready arbitrating multiplexer with one registered output stage.
// Each cycle one channel wins by fixed priority, round robin or manual select, or none wins (hold).
module rr_arb_mux #(
    parameter  int NUM_CH = 4,
    parameter  int WIDTH  = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH-1:0]       inValid,
    input  logic [NUM_CH*WIDTH-1:0] inData,
    output logic [NUM_CH-1:0]       inReady,
    output logic                    outValid,
    output logic [WIDTH-1:0]        outData,
    output logic [SEL_W-1:0]        outSel,
    input  logic                    outReady
);

    localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W:0]   NO_PICK  = {(SEL_W+1){1'b0}};

    // Pick result is {found, index}; the loops run high-to-low so the first match wins.
    function automatic logic [SEL_W:0] pick_fixed(input logic [NUM_CH-1:0] v);
        logic [SEL_W:0] r;
        r = NO_PICK;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[SEL_W'(i)]) begin
                r = {1'b1, SEL_W'(i)};
            end
        end
        return r;
    endfunction

    function automatic logic [SEL_W:0] pick_rr(input logic [NUM_CH-1:0] v,
                                               input logic [SEL_W-1:0]  ptr);
        logic [SEL_W:0]   r;
        logic [SEL_W-1:0] jx;
        int               j;
        r = NO_PICK;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_CH) begin
                j = j - NUM_CH;
            end
            jx = SEL_W'(j);
            if (v[jx]) begin
                r = {1'b1, jx};
            end
        end
        return r;
    endfunction

    logic [SEL_W:0]      pick_s;
    logic                grant_any_s;
    logic [SEL_W-1:0]    grant_idx_s;
    logic [NUM_CH-1:0]   grant_s;
    logic                can_load_s;
    logic                xfer_s;
    logic [SEL_W-1:0]    rr_next_s;

    logic                out_valid_r;
    logic [WIDTH-1:0]    out_data_r;
    logic [SEL_W-1:0]    out_sel_r;
    logic [SEL_W-1:0]    rr_ptr_r;

    // Select the winning channel for the current mode
    always_comb begin
        pick_s = NO_PICK;
        case (mode)
            2'd0: pick_s = pick_fixed(inValid);
            2'd1: pick_s = pick_rr(inValid, rr_ptr_r);
            2'd2: begin
                if (({1'b0, sel} < NUM_CH_W) && inValid[sel]) begin
                    pick_s = {1'b1, sel};
                end else begin
                    pick_s = NO_PICK;
                end
            end
            default: pick_s = NO_PICK;
        endcase
    end

    assign grant_any_s = pick_s[SEL_W];
    assign grant_idx_s = pick_s[SEL_W-1:0];

    // Expand the winning index into a one-hot grant vector
    always_comb begin
        grant_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            grant_s[SEL_W'(i)] = grant_any_s && (grant_idx_s == SEL_W'(i));
        end
    end

    // The output stage accepts a word when empty or when its word leaves this cycle
    assign can_load_s = ~out_valid_r | outReady;
    assign inReady    = grant_s & {NUM_CH{can_load_s & ~rst}};
    assign xfer_s     = grant_any_s & can_load_s & ~rst;
    assign rr_next_s  = (grant_idx_s == LAST_CH) ? {SEL_W{1'b0}} : grant_idx_s + SEL_W'(1);

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_sel_r   <= {SEL_W{1'b0}};
            rr_ptr_r    <= {SEL_W{1'b0}};
        end else begin
            if (xfer_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= inData[int'(grant_idx_s)*WIDTH +: WIDTH];
                out_sel_r   <= grant_idx_s;
            end else if (out_valid_r && outReady) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            if (xfer_s && (mode == 2'd1)) begin
                rr_ptr_r <= rr_next_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign outValid = out_valid_r;
    assign outData  = out_data_r;
    assign outSel   = out_sel_r;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: a 4-channel and a 3-channel instance share stimulus; a policy-level
// model checks both every cycle and directed literal checks pin the model.
module tb_rr_arb_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        outReady;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [3:0]  inValid;
    logic [31:0] inData;

    logic [3:0]  a_inReady;
    logic        a_outValid;
    logic [7:0]  a_outData;
    logic [1:0]  a_outSel;
    logic [2:0]  b_inReady;
    logic        b_outValid;
    logic [7:0]  b_outData;
    logic [1:0]  b_outSel;

    int n_vec = 0;
    int n_err = 0;

    rr_arb_mux #(.NUM_CH(4), .WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .inValid(inValid), .inData(inData), .inReady(a_inReady),
        .outValid(a_outValid), .outData(a_outData), .outSel(a_outSel), .outReady(outReady)
    );

    rr_arb_mux #(.NUM_CH(3), .WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .inValid(inValid[2:0]), .inData(inData[23:0]), .inReady(b_inReady),
        .outValid(b_outValid), .outData(b_outData), .outSel(b_outSel), .outReady(outReady)
    );

    always #5 clk = ~clk;

    // Behavioural model state, index 0 = 4-channel, 1 = 3-channel instance
    logic       m_v[2] = '{1'b0, 1'b0};
    logic [7:0] m_d[2] = '{8'h00, 8'h00};
    int         m_s[2] = '{0, 0};
    int         m_p[2] = '{0, 0};

    function automatic int nch(int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic logic [3:0] vin(int d);
        return (d == 0) ? inValid : {1'b0, inValid[2:0]};
    endfunction

    // Winner by the arbitration rules, -1 when nobody wins
    function automatic int winner(int n, int ptr, logic [1:0] m, int s, logic [3:0] v);
        int w;
        w = -1;
        case (m)
            2'd0: for (int i = n - 1; i >= 0; i--) if (v[i]) w = i;
            2'd1: for (int k = n - 1; k >= 0; k--) if (v[(ptr + k) % n]) w = (ptr + k) % n;
            2'd2: if (s < n && v[s]) w = s;
            default: w = -1;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] exp_rdy(int d);
        int w;
        w = winner(nch(d), m_p[d], mode, int'(sel), vin(d));
        if (rst || !(!m_v[d] || outReady) || w < 0) return 4'b0000;
        return 4'b0001 << w;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each rising edge from the inputs held during the cycle
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int w;
            w = winner(nch(d), m_p[d], mode, int'(sel), vin(d));
            if (rst) begin
                m_v[d] = 1'b0; m_d[d] = 8'h00; m_s[d] = 0; m_p[d] = 0;
            end else if ((!m_v[d] || outReady) && w >= 0) begin
                m_v[d] = 1'b1;
                m_d[d] = inData[w*8 +: 8];
                m_s[d] = w;
                if (mode == 2'd1) m_p[d] = (w + 1) % nch(d);
            end else if (m_v[d] && outReady) begin
                m_v[d] = 1'b0;
            end
        end
    end

    // Compare both instances against the model every cycle
    always @(negedge clk) begin
        check("a_inReady",  {28'b0, a_inReady},  {28'b0, exp_rdy(0)});
        check("a_outValid", {31'b0, a_outValid}, {31'b0, m_v[0]});
        check("a_outData",  {24'b0, a_outData},  {24'b0, m_d[0]});
        check("a_outSel",   {30'b0, a_outSel},   m_s[0]);
        check("b_inReady",  {29'b0, b_inReady},  {28'b0, exp_rdy(1)});
        check("b_outValid", {31'b0, b_outValid}, {31'b0, m_v[1]});
        check("b_outData",  {24'b0, b_outData},  {24'b0, m_d[1]});
        check("b_outSel",   {30'b0, b_outSel},   m_s[1]);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int rr_exp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mode = 2'd0; sel = 2'd0; inValid = 4'b1111;
        inData = 32'h44332211; outReady = 1'b1;

        // reset with all channels valid
        cyc(); cyc();
        @(negedge clk);
        check("rst_outValid", {31'b0, a_outValid}, 32'd0);
        check("rst_outData",  {24'b0, a_outData},  32'd0);
        check("rst_outSel",   {30'b0, a_outSel},   32'd0);
        check("rst_inReady",  {28'b0, a_inReady},  32'd0);

        // fixed priority
        cyc();
        rst = 1'b0; mode = 2'd0; inValid = 4'b1010;
        @(negedge clk);
        check("fix_inReady", {28'b0, a_inReady}, 32'h2);
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge clk);
            check("fix_outSel",  {30'b0, a_outSel},  32'd1);
            check("fix_outData", {24'b0, a_outData}, 32'h22);
        end

        // round robin, one word per cycle
        cyc();
        mode = 2'd1; inValid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cyc();
            @(negedge clk);
            check("rr_outSel",   {30'b0, a_outSel},   rr_exp[i]);
            check("rr_outValid", {31'b0, a_outValid}, 32'd1);
        end

        // manual select
        cyc();
        mode = 2'd2; sel = 2'd2; inValid = 4'b0100; inData = 32'h44A52211;
        cyc();
        inValid = 4'b0011;
        @(negedge clk);
        check("man_outData", {24'b0, a_outData}, 32'hA5);
        check("man_outSel",  {30'b0, a_outSel},  32'd2);
        check("man_inReady", {28'b0, a_inReady}, 32'd0);
        cyc();
        @(negedge clk);
        check("man_pop_valid", {31'b0, a_outValid}, 32'd0);
        check("man_keep_data", {24'b0, a_outData},  32'hA5);

        // backpressure, then pop and reload together
        cyc();
        mode = 2'd0; inValid = 4'b0100; inData = 32'h44C32211;
        cyc();
        outReady = 1'b0; inValid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_outValid", {31'b0, a_outValid}, 32'd1);
            check("bp_outData",  {24'b0, a_outData},  32'hC3);
            check("bp_outSel",   {30'b0, a_outSel},   32'd2);
            check("bp_inReady",  {28'b0, a_inReady},  32'd0);
            cyc();
            inValid = ~inValid; inData = ~inData;
        end
        outReady = 1'b1; inValid = 4'b1000; inData = 32'h5A000000;
        @(negedge clk);
        check("bp_reload_rdy", {28'b0, a_inReady}, 32'h8);
        cyc();
        @(negedge clk);
        check("bp_reload_data", {24'b0, a_outData}, 32'h5A);
        check("bp_reload_sel",  {30'b0, a_outSel},  32'd3);

        // 3-channel wrap and mid-stream reset
        cyc();
        mode = 2'd1; inValid = 4'b0100; inData = 32'h44332211;
        cyc();
        inValid = 4'b0111;
        @(negedge clk);
        check("wrap_last", {30'b0, b_outSel}, 32'd2);
        cyc();
        @(negedge clk);
        check("wrap_first",   {30'b0, b_outSel}, 32'd0);
        check("wrap_a_first", {30'b0, a_outSel}, 32'd0);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("mrst_a_rdy", {28'b0, a_inReady}, 32'd0);
        check("mrst_b_rdy", {29'b0, b_inReady}, 32'd0);
        cyc();
        rst = 1'b0; inValid = 4'b0110;
        @(negedge clk);
        check("mrst_a_valid", {31'b0, a_outValid}, 32'd0);
        check("mrst_b_valid", {31'b0, b_outValid}, 32'd0);
        cyc();
        @(negedge clk);
        check("mrst_b_ptr", {30'b0, b_outSel}, 32'd1);
        check("mrst_a_ptr", {30'b0, a_outSel}, 32'd1);

        mode = 2'd3;
        repeat (3) cyc();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
